// File: rtl/wb_commit_queue.sv
// Writeback commit queue: buffers retired instructions in order, drains one per
// cycle to the register file, forwards queued bytes to decode, and turns a
// head exception/ERET into a CP0 report plus a full flush.
// Optional trace outputs are enabled by defining WB_STAGE_DEBUG_TRACE_EN.
module wb_commit_queue #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 2,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ms_to_ws_valid,
    output logic                        ws_allow_in,
    input  logic [ADDR_WIDTH-1:0]       ms_pc,
    input  logic [REG_ADDR_WIDTH-1:0]   ms_write_register,
    input  logic [DATA_WIDTH/8-1:0]     ms_write_strobe,
    input  logic [DATA_WIDTH-1:0]       ms_write_data,
    input  logic                        ms_exception_valid,
    input  logic                        ms_eret_flush,
    input  logic [4:0]                  ms_exception_code,
    input  logic                        ms_in_delay_slot,
    input  logic [ADDR_WIDTH-1:0]       ms_badvaddr,
    input  logic                        ws_stall,
    output logic                        rf_write_enabled,
    output logic [REG_ADDR_WIDTH-1:0]   rf_write_address,
    output logic [DATA_WIDTH/8-1:0]     rf_write_strobe,
    output logic [DATA_WIDTH-1:0]       rf_write_data,
    input  logic [REG_ADDR_WIDTH-1:0]   id_query_register,
    output logic                        fw_hit,
    output logic [DATA_WIDTH/8-1:0]     fw_byte_valid,
    output logic [DATA_WIDTH-1:0]       fw_data,
    output logic                        cp0_exception_valid,
    output logic                        cp0_eret_flush,
    output logic [4:0]                  cp0_exception_code,
    output logic [ADDR_WIDTH-1:0]       cp0_exception_address,
    output logic                        cp0_in_delay_slot,
    output logic [ADDR_WIDTH-1:0]       cp0_badvaddr,
    output logic                        ws_flush
`ifdef WB_STAGE_DEBUG_TRACE_EN
    ,
    output logic [ADDR_WIDTH-1:0]       debug_wb_pc,
    output logic [DATA_WIDTH/8-1:0]     debug_wb_rf_wen,
    output logic [REG_ADDR_WIDTH-1:0]   debug_wb_rf_wnum,
    output logic [DATA_WIDTH-1:0]       debug_wb_rf_wdata
`endif
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    // Entry storage (no reset needed: validity is tracked by count)
    logic [ADDR_WIDTH-1:0]     pc_q     [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] reg_q    [DEPTH];
    logic [STRB_W-1:0]         strobe_q [DEPTH];
    logic [DATA_WIDTH-1:0]     data_q   [DEPTH];
    logic                      exc_q    [DEPTH];
    logic                      eret_q   [DEPTH];
    logic [4:0]                code_q   [DEPTH];
    logic                      ds_q     [DEPTH];
    logic [ADDR_WIDTH-1:0]     bad_q    [DEPTH];

    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    logic retire;
    logic flush_cycle;
    logic push;
    logic head_exc;
    logic head_eret;
    logic [PTR_W-1:0] fw_idx;

    // Control: retire, flush and acceptance decisions
    always_comb begin
        head_exc    = exc_q[head_q];
        head_eret   = eret_q[head_q];
        // Gated by reset so in-flight entries never reach the register file
        retire      = (count_q != '0) && !ws_stall && !reset;
        flush_cycle = retire && (head_exc || head_eret);
        ws_allow_in = ((count_q < CNT_W'(DEPTH)) || retire) && !flush_cycle;
        push        = ms_to_ws_valid && ws_allow_in;
    end

    // Pointer and occupancy update
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_cycle) begin
            // Discard the faulting head and everything younger
            head_q  <= tail_q;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (retire) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(retire);
        end
    end

    // Entry write at tail
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            pc_q[tail_q]     <= ms_pc;
            reg_q[tail_q]    <= ms_write_register;
            strobe_q[tail_q] <= ms_write_strobe;
            data_q[tail_q]   <= ms_write_data;
            exc_q[tail_q]    <= ms_exception_valid;
            eret_q[tail_q]   <= ms_eret_flush;
            code_q[tail_q]   <= ms_exception_code;
            ds_q[tail_q]     <= ms_in_delay_slot;
            bad_q[tail_q]    <= ms_badvaddr;
        end
    end

    // Head outputs: register-file write or CP0 report
    always_comb begin
        rf_write_enabled      = 1'b0;
        rf_write_address      = '0;
        rf_write_strobe       = '0;
        rf_write_data         = '0;
        cp0_exception_valid   = 1'b0;
        cp0_eret_flush        = 1'b0;
        cp0_exception_code    = '0;
        cp0_exception_address = '0;
        cp0_in_delay_slot     = 1'b0;
        cp0_badvaddr          = '0;
        ws_flush              = 1'b0;
        if (flush_cycle) begin
            cp0_exception_valid   = head_exc;
            cp0_eret_flush        = head_eret && !head_exc;
            cp0_exception_code    = code_q[head_q];
            cp0_exception_address = pc_q[head_q];
            cp0_in_delay_slot     = ds_q[head_q];
            cp0_badvaddr          = bad_q[head_q];
            ws_flush              = 1'b1;
        end else if (retire && (reg_q[head_q] != '0) && (strobe_q[head_q] != '0)) begin
            rf_write_enabled = 1'b1;
            rf_write_address = reg_q[head_q];
            rf_write_strobe  = strobe_q[head_q];
            rf_write_data    = data_q[head_q];
        end
    end

    // Forwarding: walk oldest to youngest so younger bytes overwrite older ones
    always_comb begin
        fw_hit        = 1'b0;
        fw_byte_valid = '0;
        fw_data       = '0;
        fw_idx        = head_q;
        if (id_query_register != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                fw_idx = head_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && !exc_q[fw_idx] && !eret_q[fw_idx] &&
                    (reg_q[fw_idx] == id_query_register)) begin
                    fw_hit = 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (strobe_q[fw_idx][b]) begin
                            fw_byte_valid[b]  = 1'b1;
                            fw_data[8*b +: 8] = data_q[fw_idx][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

`ifdef WB_STAGE_DEBUG_TRACE_EN
    // Retirement trace, zero when nothing retires
    always_comb begin
        debug_wb_pc       = retire ? pc_q[head_q] : '0;
        debug_wb_rf_wen   = rf_write_strobe;
        debug_wb_rf_wnum  = rf_write_address;
        debug_wb_rf_wdata = rf_write_data;
    end
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Scoreboard bench for wb_commit_queue: stimulus pushes expected rf writes and
// CP0 reports; a negedge monitor pops and compares whenever the DUT presents one.
module tb_wb_commit_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allow_in;
    logic [31:0] ms_pc;
    logic [4:0]  ms_write_register;
    logic [3:0]  ms_write_strobe;
    logic [31:0] ms_write_data;
    logic        ms_exception_valid;
    logic        ms_eret_flush;
    logic [4:0]  ms_exception_code;
    logic        ms_in_delay_slot;
    logic [31:0] ms_badvaddr;
    logic        ws_stall;
    logic        rf_write_enabled;
    logic [4:0]  rf_write_address;
    logic [3:0]  rf_write_strobe;
    logic [31:0] rf_write_data;
    logic [4:0]  id_query_register;
    logic        fw_hit;
    logic [3:0]  fw_byte_valid;
    logic [31:0] fw_data;
    logic        cp0_exception_valid;
    logic        cp0_eret_flush;
    logic [4:0]  cp0_exception_code;
    logic [31:0] cp0_exception_address;
    logic        cp0_in_delay_slot;
    logic [31:0] cp0_badvaddr;
    logic        ws_flush;

    wb_commit_queue #(
        .DATA_WIDTH     (32),
        .DEPTH          (2),
        .REG_ADDR_WIDTH (5),
        .ADDR_WIDTH     (32)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .ms_to_ws_valid        (ms_to_ws_valid),
        .ws_allow_in           (ws_allow_in),
        .ms_pc                 (ms_pc),
        .ms_write_register     (ms_write_register),
        .ms_write_strobe       (ms_write_strobe),
        .ms_write_data         (ms_write_data),
        .ms_exception_valid    (ms_exception_valid),
        .ms_eret_flush         (ms_eret_flush),
        .ms_exception_code     (ms_exception_code),
        .ms_in_delay_slot      (ms_in_delay_slot),
        .ms_badvaddr           (ms_badvaddr),
        .ws_stall              (ws_stall),
        .rf_write_enabled      (rf_write_enabled),
        .rf_write_address      (rf_write_address),
        .rf_write_strobe       (rf_write_strobe),
        .rf_write_data         (rf_write_data),
        .id_query_register     (id_query_register),
        .fw_hit                (fw_hit),
        .fw_byte_valid         (fw_byte_valid),
        .fw_data               (fw_data),
        .cp0_exception_valid   (cp0_exception_valid),
        .cp0_eret_flush        (cp0_eret_flush),
        .cp0_exception_code    (cp0_exception_code),
        .cp0_exception_address (cp0_exception_address),
        .cp0_in_delay_slot     (cp0_in_delay_slot),
        .cp0_badvaddr          (cp0_badvaddr),
        .ws_flush              (ws_flush)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  addr;
        logic [3:0]  strobe;
        logic [31:0] data;
    } rf_exp_t;

    typedef struct packed {
        logic        exc;
        logic        eret;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
    } cp0_exp_t;

    rf_exp_t  rf_q[$];
    cp0_exp_t cp0_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each presented rf write / CP0 report against the scoreboard
    always @(negedge clock) begin
        if (rf_write_enabled === 1'b1) begin
            rf_exp_t e;
            if (rf_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rf_unexpected actual=%0h required=none",
                         {rf_write_address, rf_write_strobe, rf_write_data});
            end else begin
                e = rf_q.pop_front();
                chk("rf_write", {23'd0, rf_write_address, rf_write_strobe, rf_write_data}, {23'd0, e});
            end
        end
        if ((cp0_exception_valid === 1'b1) || (cp0_eret_flush === 1'b1)) begin
            cp0_exp_t c;
            if (cp0_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cp0_unexpected actual=%0h required=none", cp0_exception_address);
            end else begin
                c = cp0_q.pop_front();
                chk("cp0_flags", {61'd0, cp0_exception_valid, cp0_eret_flush, ws_flush},
                    {61'd0, c.exc, c.eret, 1'b1});
                chk("cp0_code_ds", {57'd0, cp0_exception_code, cp0_in_delay_slot},
                    {57'd0, c.code, c.ds});
                chk("cp0_pc_bad", {cp0_exception_address, cp0_badvaddr}, {c.pc, c.bad});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rg, input logic [3:0] st,
                         input logic [31:0] d, input logic exc, input logic eret,
                         input logic [4:0] code, input logic ds, input logic [31:0] bad);
        ms_to_ws_valid     = 1'b1;
        ms_pc              = pc;
        ms_write_register  = rg;
        ms_write_strobe    = st;
        ms_write_data      = d;
        ms_exception_valid = exc;
        ms_eret_flush      = eret;
        ms_exception_code  = code;
        ms_in_delay_slot   = ds;
        ms_badvaddr        = bad;
    endtask

    task automatic drive_rf(input logic [31:0] pc, input logic [4:0] rg, input logic [3:0] st,
                            input logic [31:0] d);
        drive(pc, rg, st, d, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic idle();
        ms_to_ws_valid     = 1'b0;
        ms_exception_valid = 1'b0;
        ms_eret_flush      = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ws_stall = 1'b0;
        id_query_register = 5'd0;
        idle();
        drive_rf(32'd0, 5'd0, 4'd0, 32'd0);
        idle();
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("reset_allow_in", {63'd0, ws_allow_in}, 64'd1);
        chk("reset_outputs", {60'd0, rf_write_enabled, cp0_exception_valid, cp0_eret_flush, ws_flush},
            64'd0);

        // Single enqueue then retire
        tick();
        id_query_register = 5'd8;
        drive_rf(32'hBFC0_0000, 5'd8, 4'hF, 32'h1234_5678);
        rf_q.push_back({5'd8, 4'hF, 32'h1234_5678});
        tick();
        idle();
        @(negedge clock);
        chk("single_fw", {27'd0, fw_hit, fw_byte_valid, fw_data}, {27'd0, 1'b1, 4'hF, 32'h1234_5678});
        tick();
        @(negedge clock);
        chk("single_drained", {62'd0, fw_hit, rf_write_enabled}, 64'd0);

        // Full queue, then simultaneous push and pop
        tick();
        ws_stall = 1'b1;
        drive_rf(32'h100, 5'd9, 4'hF, 32'h1111_1111);
        tick();
        drive_rf(32'h104, 5'd10, 4'hF, 32'h2222_2222);
        tick();
        idle();
        @(negedge clock);
        chk("full_allow_in", {63'd0, ws_allow_in}, 64'd0);
        chk("stalled_no_write", {63'd0, rf_write_enabled}, 64'd0);
        tick();
        ws_stall = 1'b0;
        drive_rf(32'h108, 5'd11, 4'hF, 32'h3333_3333);
        rf_q.push_back({5'd9, 4'hF, 32'h1111_1111});
        rf_q.push_back({5'd10, 4'hF, 32'h2222_2222});
        rf_q.push_back({5'd11, 4'hF, 32'h3333_3333});
        @(negedge clock);
        chk("full_push_pop_allow", {63'd0, ws_allow_in}, 64'd1);
        tick();
        idle();
        tick();
        tick();
        @(negedge clock);
        chk("full_drained", {63'd0, rf_write_enabled}, 64'd0);

        // Byte merge forwarding, younger partial over older full
        tick();
        ws_stall = 1'b1;
        drive_rf(32'h200, 5'd5, 4'hF, 32'hAABB_CCDD);
        tick();
        drive_rf(32'h204, 5'd5, 4'h3, 32'h0000_1122);
        tick();
        idle();
        id_query_register = 5'd5;
        @(negedge clock);
        chk("merge_fw", {27'd0, fw_hit, fw_byte_valid, fw_data}, {27'd0, 1'b1, 4'hF, 32'hAABB_1122});
        id_query_register = 5'd6;
        #1;
        chk("merge_miss", {27'd0, fw_hit, fw_byte_valid, fw_data}, 64'd0);
        tick();
        ws_stall = 1'b0;
        rf_q.push_back({5'd5, 4'hF, 32'hAABB_CCDD});
        rf_q.push_back({5'd5, 4'h3, 32'h0000_1122});
        tick();
        @(negedge clock);
        id_query_register = 5'd5;
        #1;
        chk("merge_partial_left", {27'd0, fw_hit, fw_byte_valid, fw_data},
            {27'd0, 1'b1, 4'h3, 32'h0000_1122});
        tick();

        // Exception at head with a younger entry behind it
        ws_stall = 1'b1;
        drive(32'h8000_0100, 5'd12, 4'hF, 32'hCAFE_0001, 1'b1, 1'b0, 5'h04, 1'b0, 32'h0000_0003);
        tick();
        drive_rf(32'h8000_0104, 5'd13, 4'hF, 32'hCAFE_0002);
        tick();
        idle();
        id_query_register = 5'd12;
        @(negedge clock);
        chk("exc_not_forwarded", {63'd0, fw_hit}, 64'd0);
        id_query_register = 5'd13;
        #1;
        chk("younger_forwarded", {63'd0, fw_hit}, 64'd1);
        tick();
        ws_stall = 1'b0;
        drive_rf(32'h8000_0108, 5'd14, 4'hF, 32'hCAFE_0003);
        cp0_q.push_back({1'b1, 1'b0, 5'h04, 32'h8000_0100, 1'b0, 32'h0000_0003});
        @(negedge clock);
        chk("exc_flush_cycle", {61'd0, ws_flush, ws_allow_in, rf_write_enabled}, {61'd0, 3'b100});
        tick();
        idle();
        @(negedge clock);
        chk("exc_after", {60'd0, ws_flush, cp0_exception_valid, rf_write_enabled, fw_hit}, 64'd0);
        tick();
        @(negedge clock);
        chk("exc_queue_empty", {62'd0, rf_write_enabled, ws_allow_in}, 64'd1);

        // Register 0 write and query
        ws_stall = 1'b1;
        drive_rf(32'h300, 5'd0, 4'hF, 32'hDEAD_BEEF);
        tick();
        idle();
        id_query_register = 5'd0;
        @(negedge clock);
        chk("reg0_query", {27'd0, fw_hit, fw_byte_valid, fw_data}, 64'd0);
        tick();
        ws_stall = 1'b0;
        @(negedge clock);
        chk("reg0_no_write", {63'd0, rf_write_enabled}, 64'd0);
        tick();

        // ERET head, then a head with both flags (exception wins)
        drive(32'h8000_0200, 5'd3, 4'hF, 32'h0, 1'b0, 1'b1, 5'd0, 1'b1, 32'd0);
        cp0_q.push_back({1'b0, 1'b1, 5'd0, 32'h8000_0200, 1'b1, 32'd0});
        tick();
        idle();
        @(negedge clock);
        chk("eret_no_write", {63'd0, rf_write_enabled}, 64'd0);
        tick();
        drive(32'h8000_0300, 5'd4, 4'hF, 32'h0, 1'b1, 1'b1, 5'h0C, 1'b0, 32'h1234);
        cp0_q.push_back({1'b1, 1'b0, 5'h0C, 32'h8000_0300, 1'b0, 32'h1234});
        tick();
        idle();
        tick();

        // Reset with two queued entries discards them
        ws_stall = 1'b1;
        drive_rf(32'h400, 5'd20, 4'hF, 32'h5555_5555);
        tick();
        drive_rf(32'h404, 5'd21, 4'hF, 32'h6666_6666);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ws_stall = 1'b0;
        id_query_register = 5'd20;
        @(negedge clock);
        chk("midreset_state", {61'd0, ws_allow_in, rf_write_enabled, fw_hit}, 64'd4);
        tick();
        tick();

        chk("rf_scoreboard_empty", 64'(rf_q.size()), 64'd0);
        chk("cp0_scoreboard_empty", 64'(cp0_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_commit_queue.md
Name: wb_commit_queue

Overview:
- Parametrised next-generation writeback stage for the MIPS core.
- Sits between the memory stage and the register file / CP0.
- Buffers up to DEPTH retired instructions in order and drains one per cycle to the register file with byte strobes.
- Provides byte-granular youngest-first forwarding to the decode stage, and converts a head-of-queue exception or ERET into a one-cycle CP0 report plus a full queue flush.

Parameters:
- DATA_WIDTH, 32, register/data width; must be a multiple of 8.
- DEPTH, 2, queue entries; power of two, at least 2.
- REG_ADDR_WIDTH, 5, register-file address width.
- ADDR_WIDTH, 32, PC / bad-address width.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- ms_to_ws_valid  in  1  memory stage offers an entry
- ws_allow_in  out  1  queue accepts this cycle
- ms_pc  in  ADDR_WIDTH  instruction PC
- ms_write_register  in  REG_ADDR_WIDTH  destination register
- ms_write_strobe  in  DATA_WIDTH/8  byte enables
- ms_write_data  in  DATA_WIDTH  result
- ms_exception_valid  in  1  instruction faulted
- ms_eret_flush  in  1  instruction is ERET
- ms_exception_code  in  5  ExcCode
- ms_in_delay_slot  in  1  branch delay slot flag
- ms_badvaddr  in  ADDR_WIDTH  faulting address
- ws_stall  in  1  hold head (CP0 busy, debug halt)
- rf_write_enabled  out  1  register-file write
- rf_write_address  out  REG_ADDR_WIDTH  write address
- rf_write_strobe  out  DATA_WIDTH/8  write byte enables
- rf_write_data  out  DATA_WIDTH  write data
- id_query_register  in  REG_ADDR_WIDTH  decode source operand
- fw_hit  out  1  a queued entry targets the queried register
- fw_byte_valid  out  DATA_WIDTH/8  bytes supplied by the queue
- fw_data  out  DATA_WIDTH  merged forwarded bytes
- cp0_exception_valid  out  1  exception report pulse
- cp0_eret_flush  out  1  ERET report pulse
- cp0_exception_code  out  5  ExcCode
- cp0_exception_address  out  ADDR_WIDTH  EPC source
- cp0_in_delay_slot  out  1  delay slot flag
- cp0_badvaddr  out  ADDR_WIDTH  bad virtual address
- ws_flush  out  1  pipeline flush pulse

Behaviour:
- Reset: queue empty, head and tail pointers 0, count 0. All outputs 0 except ws_allow_in = 1.
- Storage: circular buffer with head/tail pointers of width log2(DEPTH) that wrap naturally, plus a count register of width log2(DEPTH)+1.
- Enqueue when ms_to_ws_valid && ws_allow_in; the entry is written at tail.
- ws_allow_in = (count < DEPTH || retire) && !flush_cycle.
  - A full queue accepts in the same cycle the head retires (simultaneous push and pop; count unchanged).
- Retire: retire = count != 0 && !ws_stall. The head is popped at the clock edge; outputs are combinational from the head.
- Normal head, no exception or ERET:
  - rf_write_enabled = 1 when write_register != 0 and strobe != 0.
  - Address, strobe and data are driven from the head entry.
  - A head writing register 0 retires with no write.
- Exception or ERET head:
  - rf_write_enabled = 0.
  - cp0_exception_valid (or cp0_eret_flush) = 1 for exactly that cycle, with code, PC, delay-slot flag and badvaddr taken from the head.
  - ws_flush = 1 in the same cycle. At the edge the queue empties: count = 0, head = tail. Any concurrent enqueue is dropped because ws_allow_in = 0 (flush_cycle).
  - If an entry has both flags set, exception takes priority; eret_flush is reported 0.
- CP0 and flush outputs are 0 whenever no such head is retiring. A stalled head produces no rf write and no CP0 pulse.
- Forwarding, combinational:
  - For each byte b, scan valid entries from youngest to oldest. The first entry whose write_register == id_query_register with strobe[b] = 1 supplies byte b; fw_byte_valid[b] = 1.
  - fw_hit = 1 if any valid entry matches the register, regardless of strobe.
  - Entries with exception or ERET flags are excluded from forwarding.
  - Query register 0: fw_hit = 0, fw_byte_valid = 0, fw_data = 0.
  - Bytes not supplied read 0.
  - fw_hit with an incomplete fw_byte_valid means decode must merge with register-file data. Decode owns that merge.
- Mid-operation reset: the queue is cleared on the next edge and in-flight entries are discarded with no rf write.

Optional Feature:
- WB_STAGE_DEBUG_TRACE_EN defined adds four outputs:
  - debug_wb_pc (ADDR_WIDTH)
  - debug_wb_rf_wen (DATA_WIDTH/8)
  - debug_wb_rf_wnum (REG_ADDR_WIDTH)
  - debug_wb_rf_wdata (DATA_WIDTH)
- Trace behaviour:
  - Valid on every retire: PC of the retiring head, wen = rf_write_strobe gated by rf_write_enabled.
  - Zero when not retiring or after reset.
- Macro undefined: ports absent, no PC storage per entry beyond what CP0 reporting needs, identical functional behaviour.

Test Plan:
- Reset, then single enqueue: pc=0xBFC00000, reg=8, strobe=0xF, data=0x12345678, stall=0 → next cycle rf_write_enabled=1, address=8, data=0x12345678; count returns to 0.
- Full with push/pop: stall=1, enqueue two entries (DEPTH=2) → ws_allow_in=0. Then stall=0 with a valid third entry → accepted in the same cycle the head retires; in-order writes follow.
- Byte merge: queue holds reg=5 strobe=0xF data=0xAABBCCDD (older) and reg=5 strobe=0x3 data=0x00001122 (younger); query 5 → fw_hit=1, fw_byte_valid=0xF, fw_data=0xAABB1122.
- Exception at head: head has exception_valid=1, code=0x04, badvaddr=0x00000003, one younger entry behind it → cp0_exception_valid=1 and ws_flush=1 for one cycle, ws_allow_in=0, no rf write; queue empty afterward.
- Register 0 and ERET: enqueue reg=0 strobe=0xF → no rf write and query 0 returns 0. Then an ERET head → cp0_eret_flush=1, cp0_exception_valid=0.
- Reset mid-operation: reset asserted with two queued entries → next cycle count=0, ws_allow_in=1, no rf write.
